// File: rtl/neonfox_pkg.sv
// Shared package for the return-stack slice: operation encoding and the
// width helpers used to size the count and pointer registers.
package neonfox_pkg;

  // Decoded stack operation for one cycle.
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address the depth-1 entry backing array (at least 1).
  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Backing array for the return stack: ENTRIES x WIDTH, one asynchronous
// read port and one synchronous write port, built from logic cells.
module stack_ram #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 15,
  parameter int AW      = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  (* ramstyle = "logic" *) logic [WIDTH-1:0] mem_q [ENTRIES];

  // Write port: store one entry on the rising edge when enabled.
  // NOTE: the array has no reset; entries are only read after being written,
  // so clearing them would cost a mux per bit for no functional benefit.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_stack.sv
// Return stack with a dedicated top-of-stack register in front of a
// circular backing array. Optional sticky overflow/underflow flags are
// built when RET_STACK_ERR_EN is defined.
module ret_stack
  import neonfox_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef RET_STACK_ERR_EN
  output logic                      overflow,
  output logic                      underflow,
`endif
  input  logic                      en,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      empty,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW      = cnt_w(DEPTH);
  localparam int AW      = ptr_w(DEPTH);
  localparam int ENTRIES = DEPTH - 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 2);

  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [AW-1:0]    wptr_inc, wptr_dec;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_we;
  logic             do_push;
  op_e              op;
`ifdef RET_STACK_ERR_EN
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
`endif

  assign data_out = top_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
`ifdef RET_STACK_ERR_EN
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  // Pointer neighbours with explicit wrap so non-power-of-two depths work.
  assign wptr_inc = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
  assign wptr_dec = (wptr_q == '0) ? LAST_PTR : wptr_q - 1'b1;

  stack_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (top_q),
    .raddr_i (wptr_dec),
    .rdata_o (mem_rdata)
  );

  // Decode the request lines into one operation; flush or en low masks all.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    op = OP_NONE;
    if (en && !flush) begin
      case ({push, pop})
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        2'b11:   op = OP_REPLACE;
        default: op = OP_NONE;
      endcase
    end
  end

  // Next-state logic for count, pointer, top register and error flags.
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    top_d   = top_q;
    mem_we  = 1'b0;
`ifdef RET_STACK_ERR_EN
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
`endif
    // A replace on an empty stack behaves exactly like a push.
    do_push = (op == OP_PUSH) || ((op == OP_REPLACE) && empty);

    if (en && flush) begin
      count_d = '0;
      wptr_d  = '0;
`ifdef RET_STACK_ERR_EN
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
`endif
    end else if (do_push) begin
      if (empty) begin
        // First entry lives only in the top register.
        top_d   = data_in;
        count_d = count_q + 1'b1;
      end else if (full) begin
`ifdef RET_STACK_ERR_EN
        overflow_d = 1'b1;
`endif
        if (WRAP != 0) begin
          // When full the pointer sits on the oldest entry, so spilling the
          // top there overwrites it while count stays at DEPTH.
          mem_we = 1'b1;
          wptr_d = wptr_inc;
          top_d  = data_in;
        end
      end else begin
        mem_we  = 1'b1;
        wptr_d  = wptr_inc;
        top_d   = data_in;
        count_d = count_q + 1'b1;
      end
    end else if (op == OP_REPLACE) begin
      top_d = data_in;
    end else if (op == OP_POP) begin
      if (empty) begin
`ifdef RET_STACK_ERR_EN
        underflow_d = 1'b1;
`endif
      end else if (count_q == CW'(1)) begin
        // Last entry popped: top register keeps its stale value.
        count_d = '0;
      end else begin
        top_d   = mem_rdata;
        wptr_d  = wptr_dec;
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      top_q   <= '0;
`ifdef RET_STACK_ERR_EN
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      top_q   <= top_d;
`ifdef RET_STACK_ERR_EN
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`endif
    end
  end

endmodule

// File: tb/tb_ret_stack.sv
// Directed testbench for ret_stack: two DEPTH=4 instances, one dropping
// pushes on overflow (WRAP=0) and one overwriting the oldest entry (WRAP=1).
module tb_ret_stack;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         en0 = 1'b1, flush0 = 1'b0, push0 = 1'b0, pop0 = 1'b0;
  logic [W-1:0] din0 = '0, dout0;
  logic         empty0, full0;
  logic [2:0]   count0;

  logic         en1 = 1'b1, flush1 = 1'b0, push1 = 1'b0, pop1 = 1'b0;
  logic [W-1:0] din1 = '0, dout1;
  logic         empty1, full1;
  logic [2:0]   count1;

`ifdef RET_STACK_ERR_EN
  logic ovf0, unf0, ovf1, unf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ret_stack #(.WIDTH(W), .DEPTH(4), .WRAP(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
`ifdef RET_STACK_ERR_EN
    .overflow (ovf0),
    .underflow(unf0),
`endif
    .en       (en0),
    .flush    (flush0),
    .push     (push0),
    .pop      (pop0),
    .data_in  (din0),
    .data_out (dout0),
    .empty    (empty0),
    .full     (full0),
    .count    (count0)
  );

  ret_stack #(.WIDTH(W), .DEPTH(4), .WRAP(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
`ifdef RET_STACK_ERR_EN
    .overflow (ovf1),
    .underflow(unf1),
`endif
    .en       (en1),
    .flush    (flush1),
    .push     (push1),
    .pop      (pop1),
    .data_in  (din1),
    .data_out (dout1),
    .empty    (empty1),
    .full     (full1),
    .count    (count1)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs to the selected instance, then return to idle
  // 1 time unit after the rising edge so outputs can be sampled.
  task automatic op(input bit which, input bit e, input bit f, input bit p,
                    input bit q, input logic [W-1:0] d);
    if (which == 1'b0) begin
      en0 = e; flush0 = f; push0 = p; pop0 = q; din0 = d;
    end else begin
      en1 = e; flush1 = f; push1 = p; pop1 = q; din1 = d;
    end
    @(posedge clk);
    #1;
    en0 = 1'b1; flush0 = 1'b0; push0 = 1'b0; pop0 = 1'b0;
    en1 = 1'b1; flush1 = 1'b0; push1 = 1'b0; pop1 = 1'b0;
  endtask

  task automatic do_push(input bit which, input logic [W-1:0] d);
    op(which, 1'b1, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic do_pop(input bit which);
    op(which, 1'b1, 1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    logic [W-1:0] exp_pop [3];

    // Reset state, before any clock edge.
    #2;
    check("rst_count0", 32'(count0), 32'd0);
    check("rst_empty0", 32'(empty0), 32'd1);
    check("rst_full0",  32'(full0),  32'd0);
    check("rst_dout0",  dout0,       32'd0);
    check("rst_dout1",  dout1,       32'd0);
`ifdef RET_STACK_ERR_EN
    check("rst_ovf0", 32'(ovf0), 32'd0);
    check("rst_unf0", 32'(unf0), 32'd0);
`endif
    #10 rst = 1'b0;

    // Basic LIFO order: push A,B,C then pop three times.
    do_push(1'b0, 32'hA);
    do_push(1'b0, 32'hB);
    do_push(1'b0, 32'hC);
    check("lifo_top_c",   dout0,        32'hC);
    check("lifo_cnt3",    32'(count0),  32'd3);
    do_pop(1'b0);
    check("lifo_pop1",    dout0,        32'hB);
    check("lifo_cnt2",    32'(count0),  32'd2);
    do_pop(1'b0);
    check("lifo_pop2",    dout0,        32'hA);
    check("lifo_cnt1",    32'(count0),  32'd1);
    do_pop(1'b0);
    check("lifo_pop3",    dout0,        32'hA);
    check("lifo_cnt0",    32'(count0),  32'd0);
    check("lifo_empty",   32'(empty0),  32'd1);

    // Overflow with WRAP=0: the fifth push is dropped.
    for (int i = 1; i <= 5; i++) do_push(1'b0, W'(i));
    check("drop_cnt",  32'(count0), 32'd4);
    check("drop_full", 32'(full0),  32'd1);
    check("drop_dout", dout0,       32'd4);
`ifdef RET_STACK_ERR_EN
    check("drop_ovf",  32'(ovf0),   32'd1);
`endif
    for (int i = 4; i >= 1; i--) begin
      check($sformatf("drop_popval%0d", i), dout0, W'(i));
      do_pop(1'b0);
    end
    check("drop_cnt_end", 32'(count0), 32'd0);

    // Replace: count=2 top=0x10, push&pop with 0x99.
    do_push(1'b0, 32'h20);
    do_push(1'b0, 32'h10);
    check("repl_pre_top", dout0, 32'h10);
    op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h99);
    check("repl_dout", dout0,       32'h99);
    check("repl_cnt",  32'(count0), 32'd2);
    do_pop(1'b0);
    check("repl_below", dout0,       32'h20);
    check("repl_cnt1",  32'(count0), 32'd1);
    do_pop(1'b0);

    // Replace on empty acts as a push.
    op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55);
    check("repl_empty_dout", dout0,       32'h55);
    check("repl_empty_cnt",  32'(count0), 32'd1);
    do_pop(1'b0);

    // Pop on empty, flush, and en low.
    do_pop(1'b0);
    check("unf_cnt",  32'(count0), 32'd0);
    check("unf_dout", dout0,       32'h55);
`ifdef RET_STACK_ERR_EN
    check("unf_flag", 32'(unf0),   32'd1);
`endif
    op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h77);
    check("flush_cnt", 32'(count0), 32'd0);
`ifdef RET_STACK_ERR_EN
    check("flush_unf", 32'(unf0),   32'd0);
    check("flush_ovf", 32'(ovf0),   32'd0);
`endif
    op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h66);
    check("en0_cnt",  32'(count0), 32'd0);
    check("en0_dout", dout0,       32'h55);

    // Flush of a non-empty stack keeps the top register, then restarts.
    do_push(1'b0, 32'h5);
    do_push(1'b0, 32'h6);
    op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0);
    check("flushne_cnt",  32'(count0), 32'd0);
    check("flushne_dout", dout0,       32'h6);
    check("flushne_empty", 32'(empty0), 32'd1);
    do_push(1'b0, 32'h7);
    check("flushne_push_cnt",  32'(count0), 32'd1);
    check("flushne_push_dout", dout0,       32'h7);
    do_pop(1'b0);

    // Overflow with WRAP=1: oldest entries are overwritten.
    for (int i = 1; i <= 6; i++) do_push(1'b1, W'(i));
    check("wrap_cnt",  32'(count1), 32'd4);
    check("wrap_full", 32'(full1),  32'd1);
    check("wrap_dout", dout1,       32'd6);
`ifdef RET_STACK_ERR_EN
    check("wrap_ovf",  32'(ovf1),   32'd1);
`endif
    exp_pop[0] = 32'd5;
    exp_pop[1] = 32'd4;
    exp_pop[2] = 32'd3;
    for (int i = 0; i < 3; i++) begin
      do_pop(1'b1);
      check($sformatf("wrap_pop%0d", i), dout1, exp_pop[i]);
      check($sformatf("wrap_popcnt%0d", i), 32'(count1), W'(3 - i));
    end

    // Asynchronous reset in the middle of a push burst.
    do_push(1'b0, 32'h31);
    do_push(1'b0, 32'h32);
    push0 = 1'b1;
    din0  = 32'h33;
    #3 rst = 1'b1;
    #1;
    check("arst_cnt",   32'(count0), 32'd0);
    check("arst_dout",  dout0,       32'd0);
    check("arst_empty", 32'(empty0), 32'd1);
    push0 = 1'b0;
    @(posedge clk);
    #1;
    check("arst_hold_cnt", 32'(count0), 32'd0);
    #2 rst = 1'b0;
    do_push(1'b0, 32'h44);
    check("arst_post_cnt",  32'(count0), 32'd1);
    check("arst_post_dout", dout0,       32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
